// File: rtl/train_pkg.sv
// Shared track/train constants: sensor conditioner defaults and the sensor
// index map also used by the TrainState controller.
package train_pkg;

  localparam int unsigned NUM_SENSORS_DEF     = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 8;
  localparam int unsigned CNT_W_DEF           = 4;
  localparam int unsigned MAX_ACTIVE_DEF      = 2;

  localparam int unsigned SENSOR_1 = 1;
  localparam int unsigned SENSOR_2 = 2;
  localparam int unsigned SENSOR_3 = 3;
  localparam int unsigned SENSOR_4 = 4;

endpackage

// File: rtl/track_sensor_conditioner_if.sv
// Sensor bus between the raw contacts and TrainState: raw levels in,
// conditioned levels, edge pulses and the sticky fault out.
interface track_sensor_conditioner_if
  import train_pkg::*;
#(
  parameter int unsigned NUM_SENSORS = NUM_SENSORS_DEF
);

  logic [NUM_SENSORS:1] SR_RAW;
  logic [NUM_SENSORS:1] SR;
  logic [NUM_SENSORS:1] SR_RISE;
  logic [NUM_SENSORS:1] SR_FALL;
  logic                 SENSOR_FAULT;

  modport master (
    output SR_RAW,
    input  SR, SR_RISE, SR_FALL, SENSOR_FAULT
  );

  modport slave (
    input  SR_RAW,
    output SR, SR_RISE, SR_FALL, SENSOR_FAULT
  );

endinterface

// File: rtl/track_sensor_conditioner_debounce_bit.sv
// One sensor channel: two-flop synchroniser, debounce counter, stable level
// and registered single-cycle rise/fall pulses.
module sensor_debounce_bit
  import train_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Any cycle where the synchronised value matches the stable level restarts
  // qualification, so only an unbroken run of DEBOUNCE_CYCLES is accepted.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/track_sensor_conditioner.sv
// Track sensor conditioner: per-sensor debounce channels plus a sticky
// fault when more sensors are occupied than trains can account for.
module track_sensor_conditioner
  import train_pkg::*;
#(
  parameter int unsigned NUM_SENSORS     = NUM_SENSORS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned MAX_ACTIVE      = MAX_ACTIVE_DEF
) (
  input  logic                        Clock,
  input  logic                        RESET,
  track_sensor_conditioner_if.slave   bus
);

  localparam int unsigned POP_W = $clog2(NUM_SENSORS + 1);

  logic [NUM_SENSORS:1] sr_w;
  logic [NUM_SENSORS:1] rise_w;
  logic [NUM_SENSORS:1] fall_w;
  logic [POP_W-1:0]     pop;
  logic                 fault_q, fault_d;

  for (genvar g = 1; g <= NUM_SENSORS; g++) begin : g_bit
    sensor_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk_i   (Clock),
      .rst_i   (RESET),
      .raw_i   (bus.SR_RAW[g]),
      .level_o (sr_w[g]),
      .rise_o  (rise_w[g]),
      .fall_o  (fall_w[g])
    );
  end

  // Popcount of the registered levels, so the fault lands one edge after SR.
  always_comb begin
    pop = '0;
    for (int unsigned i = 1; i <= NUM_SENSORS; i++) begin
      pop = pop + POP_W'(sr_w[i]);
    end
    fault_d = fault_q | (pop > POP_W'(MAX_ACTIVE));
  end

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign bus.SR           = sr_w;
  assign bus.SR_RISE      = rise_w;
  assign bus.SR_FALL      = fall_w;
  assign bus.SENSOR_FAULT = fault_q;

endmodule

// File: tb/tb_track_sensor_conditioner.sv
// Directed bench for track_sensor_conditioner: expectations are queued with
// the cycle they are due and compared on the falling edge of that cycle.
module tb_track_sensor_conditioner;
  import train_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  track_sensor_conditioner_if #(.NUM_SENSORS(4)) bus ();

  track_sensor_conditioner #(
    .NUM_SENSORS     (4),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4),
    .MAX_ACTIVE      (2)
  ) dut (
    .Clock (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    string      tag;
    logic [4:1] sr;
    logic [4:1] rise;
    logic [4:1] fall;
    logic       fault;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int at, input string tag, input logic [4:1] sr,
                           input logic [4:1] rise, input logic [4:1] fall,
                           input logic fault);
    exp_t e;
    e.cyc = at; e.tag = tag; e.sr = sr; e.rise = rise; e.fall = fall; e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic chk_now(input string tag, input logic [4:1] sr, input logic [4:1] rise,
                         input logic [4:1] fall, input logic fault);
    checks++;
    assert ({bus.SR, bus.SR_RISE, bus.SR_FALL, bus.SENSOR_FAULT} === {sr, rise, fall, fault})
    else begin
      failures++;
      $error("FAIL %s observed sr=%b rise=%b fall=%b fault=%b expected sr=%b rise=%b fall=%b fault=%b",
             tag, bus.SR, bus.SR_RISE, bus.SR_FALL, bus.SENSOR_FAULT, sr, rise, fall, fault);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        e = sb[i];
        checks++;
        assert ({bus.SR, bus.SR_RISE, bus.SR_FALL, bus.SENSOR_FAULT} ===
                {e.sr, e.rise, e.fall, e.fault})
        else begin
          failures++;
          $error("FAIL %s cyc=%0d observed sr=%b rise=%b fall=%b fault=%b expected sr=%b rise=%b fall=%b fault=%b",
                 e.tag, cyc, bus.SR, bus.SR_RISE, bus.SR_FALL, bus.SENSOR_FAULT,
                 e.sr, e.rise, e.fall, e.fault);
        end
        sb.delete(i);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    bus.SR_RAW = 4'b1111;
    wait_cyc(3);
    chk_now("reset_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    bus.SR_RAW = 4'b0000;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(12);

    // Clean rise and fall on sensor 1
    c = cyc;
    expect_at(c,      "idle",        4'b0000, 4'b0000, 4'b0000, 1'b0);
    bus.SR_RAW = 4'b0001;
    expect_at(c + 9,  "rise1_early", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    expect_at(c + 10, "rise1_edge",  4'b0001, 4'b0001, 4'b0000, 1'b0);
    expect_at(c + 11, "rise1_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    wait_cyc(12);
    c = cyc;
    bus.SR_RAW = 4'b0000;
    expect_at(c + 9,  "fall1_early", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    expect_at(c + 10, "fall1_edge",  4'b0000, 4'b0000, 4'b0001, 1'b0);
    expect_at(c + 11, "fall1_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_cyc(12);

    // Bounce on sensor 2: high 5, low 1, then held high
    c = cyc;
    bus.SR_RAW = 4'b0010;
    wait_cyc(5);
    bus.SR_RAW = 4'b0000;
    wait_cyc(1);
    bus.SR_RAW = 4'b0010;
    expect_at(c + 8,  "bounce_mid",  4'b0000, 4'b0000, 4'b0000, 1'b0);
    expect_at(c + 12, "bounce_rej",  4'b0000, 4'b0000, 4'b0000, 1'b0);
    expect_at(c + 15, "bounce_early",4'b0000, 4'b0000, 4'b0000, 1'b0);
    expect_at(c + 16, "bounce_edge", 4'b0010, 4'b0010, 4'b0000, 1'b0);
    expect_at(c + 17, "bounce_after",4'b0010, 4'b0000, 4'b0000, 1'b0);
    wait_cyc(18);

    // Establish sensor 4, then swap 4 -> 3 on the same edge
    c = cyc;
    bus.SR_RAW = 4'b1010;
    expect_at(c + 10, "s4_rise",     4'b1010, 4'b1000, 4'b0000, 1'b0);
    wait_cyc(12);
    c = cyc;
    bus.SR_RAW = 4'b0110;
    expect_at(c + 9,  "simul_early", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    expect_at(c + 10, "simul_edge",  4'b0110, 4'b0100, 4'b1000, 1'b0);
    expect_at(c + 11, "simul_after", 4'b0110, 4'b0000, 4'b0000, 1'b0);
    wait_cyc(12);

    // Fault: two active is legal, three trips the sticky flag
    c = cyc;
    bus.SR_RAW = 4'b0011;
    expect_at(c + 10, "two_edge",    4'b0011, 4'b0001, 4'b0100, 1'b0);
    expect_at(c + 11, "two_legal",   4'b0011, 4'b0000, 4'b0000, 1'b0);
    wait_cyc(12);
    c = cyc;
    bus.SR_RAW = 4'b0111;
    expect_at(c + 10, "three_edge",  4'b0111, 4'b0100, 4'b0000, 1'b0);
    expect_at(c + 11, "fault_set",   4'b0111, 4'b0000, 4'b0000, 1'b1);
    wait_cyc(12);
    c = cyc;
    bus.SR_RAW = 4'b0000;
    expect_at(c + 10, "fault_drop",  4'b0000, 4'b0000, 4'b0111, 1'b1);
    expect_at(c + 11, "fault_stick", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    wait_cyc(12);

    // Reset mid-count, asserted between edges
    bus.SR_RAW = 4'b0001;
    wait_cyc(6);
    chk_now("pre_reset", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    #1 rst = 1'b1;
    #1 chk_now("async_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_cyc(2);
    rst = 1'b0;
    c = cyc;
    expect_at(c + 9,  "rst_early",   4'b0000, 4'b0000, 4'b0000, 1'b0);
    expect_at(c + 10, "rst_edge",    4'b0001, 4'b0001, 4'b0000, 1'b0);
    expect_at(c + 11, "rst_after",   4'b0001, 4'b0000, 4'b0000, 1'b0);
    wait_cyc(13);

    checks++;
    assert (sb.size() == 0)
    else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
